mesh_gemv_engine: RTL

//  Parametrised successor to the mesh top-level. Holds a ROWSxCOLS signed weight matrix and computes y = W*x
//  for each streamed x vector, one column per cycle across all rows. Weight preload, x input and y output
//  all use valid/ready handshakes; adds saturation/ReLU modes, sticky overflow and output back-pressure.

---
 rtl/mesh_gemv_if.sv | 35 +++
 rtl/mesh_gemv_engine.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mesh_gemv_if.sv
// Bundle of the weight-preload, x-input and y-output channels of the GEMV engine.
// master = the side that feeds weights/vectors and consumes results; slave = the engine.
interface mesh_gemv_if #(
  parameter int DW    = 8,
  parameter int ROWS  = 16,
  parameter int COLS  = 8,
  parameter int ACC_W = 16,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) ();
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [ROW_W+COL_W-1:0]   cfg_addr;
  logic [DW-1:0]            cfg_data;
  logic                     x_valid;
  logic                     x_ready;
  logic [COLS*DW-1:0]       x_vector_flat;
  logic                     mode_sat;
  logic                     mode_relu;
  logic                     y_valid;
  logic                     y_ready;
  logic [ROWS*ACC_W-1:0]    result_flat;
  logic                     busy;
  logic                     overflow;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, x_valid, x_vector_flat, mode_sat, mode_relu, y_ready,
    input  cfg_ready, x_ready, y_valid, result_flat, busy, overflow
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, x_valid, x_vector_flat, mode_sat, mode_relu, y_ready,
    output cfg_ready, x_ready, y_valid, result_flat, busy, overflow
  );
endinterface

// File: rtl/mesh_gemv_engine.sv
// Weight-stationary GEMV: y = W*x over ROWS lanes, one column per cycle, with
// saturate/wrap accumulation, optional ReLU, sticky overflow and output back-pressure.
module mesh_gemv_engine #(
  parameter int DW    = 8,
  parameter int ROWS  = 16,
  parameter int COLS  = 8,
  parameter int ACC_W = 16,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic         clk,
  input  logic         rst,
  mesh_gemv_if.slave   bus,
  output logic [1:0]   dbg_state_o
);
  // All three channels: a transfer happens on a rising edge where valid && ready are both high.
  // Ready never depends on the same channel's valid; x_ready drops while a cfg write is offered.

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_OUTPUT  = 2'd2;

  localparam int SW = ACC_W + 2*DW + 1;
  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [ROW_W:0]   ROWS_L   = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]   COLS_L   = (COL_W+1)'(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS-1);

  logic [1:0]                state_q, state_d;
  logic signed [DW-1:0]      w_q [ROWS][COLS];
  logic signed [ACC_W-1:0]   acc_q [ROWS];
  logic signed [ACC_W-1:0]   acc_nxt [ROWS];
  logic [ROWS-1:0]           ovf_vec;
  logic [COLS*DW-1:0]        x_q;
  logic signed [DW-1:0]      x_col;
  logic [COL_W-1:0]          col_q;
  logic                      sat_q, relu_q, ovf_q;
  logic [ROWS*ACC_W-1:0]     result_q;

  logic [ROW_W-1:0] cfg_row;
  logic [COL_W-1:0] cfg_col;
  logic             cfg_in_range, cfg_fire, x_fire, last_col;

  assign {cfg_row, cfg_col} = bus.cfg_addr;
  assign cfg_in_range = ({1'b0, cfg_row} < ROWS_L) && ({1'b0, cfg_col} < COLS_L);

  assign bus.cfg_ready   = (state_q == S_IDLE);
  assign bus.x_ready     = (state_q == S_IDLE) && !bus.cfg_valid;
  assign bus.y_valid     = (state_q == S_OUTPUT);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.overflow    = ovf_q;
  assign bus.result_flat = result_q;
  assign dbg_state_o     = state_q;

  assign cfg_fire = bus.cfg_valid && bus.cfg_ready;
  assign x_fire   = bus.x_valid && bus.x_ready;
  assign last_col = (col_q == COL_LAST);
  assign x_col    = x_q[col_q*DW +: DW];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (x_fire) state_d = S_COMPUTE;
      S_COMPUTE: if (last_col) state_d = S_OUTPUT;
      S_OUTPUT:  if (bus.y_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sum is formed wide enough that neither the product nor the running total can wrap before the range test.
  always_comb begin
    logic signed [2*DW-1:0] prod;
    logic signed [SW-1:0]   sum;
    for (int r = 0; r < ROWS; r++) begin
      prod = w_q[r][col_q] * x_col;
      sum  = {{(SW-ACC_W){acc_q[r][ACC_W-1]}}, acc_q[r]} + {{(SW-2*DW){prod[2*DW-1]}}, prod};
      ovf_vec[r] = (sum > ACC_MAX) || (sum < ACC_MIN);
      if (sat_q && (sum > ACC_MAX))      acc_nxt[r] = {1'b0, {(ACC_W-1){1'b1}}};
      else if (sat_q && (sum < ACC_MIN)) acc_nxt[r] = {1'b1, {(ACC_W-1){1'b0}}};
      else                               acc_nxt[r] = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          w_q[r][c] <= '0;
    end else if (cfg_fire && cfg_in_range) begin
      w_q[cfg_row][cfg_col] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      col_q    <= '0;
      sat_q    <= 1'b0;
      relu_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else begin
      state_q <= state_d;
      if (x_fire) begin
        x_q    <= bus.x_vector_flat;
        sat_q  <= bus.mode_sat;
        relu_q <= bus.mode_relu;
        ovf_q  <= 1'b0;
        col_q  <= '0;
        for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
      end else if (state_q == S_COMPUTE) begin
        for (int r = 0; r < ROWS; r++) acc_q[r] <= acc_nxt[r];
        if (|ovf_vec) ovf_q <= 1'b1;
        col_q <= last_col ? '0 : col_q + COL_W'(1);
        if (last_col) begin
          for (int r = 0; r < ROWS; r++)
            result_q[r*ACC_W +: ACC_W] <= (relu_q && acc_nxt[r][ACC_W-1]) ? '0 : acc_nxt[r];
        end
      end
    end
  end
endmodule
